jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogador_automatico.sv | 177 +++++++++++++++++
 tb/tb_jogador_automatico.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// rtl/jogador_automatico.sv - automatic player that replays and extends the memory-game button sequence
module jogador_automatico #(
    parameter int T_JOGAR     = 10,
    parameter int T_INICIO    = 5000,
    parameter int T_APERTO    = 10,
    parameter int T_INTERVALO = 10,
    parameter int T_RODADA    = 100,
    parameter int N_JOGADAS   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       pronto,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       fim,
    output logic [3:0] db_rodada,
    output logic [3:0] db_estado
);

    localparam int T_NOVA = T_APERTO + T_INTERVALO;
    localparam int M1     = (T_JOGAR > T_INICIO) ? T_JOGAR : T_INICIO;
    localparam int M2     = (M1 > T_NOVA) ? M1 : T_NOVA;
    localparam int T_MAX  = (M2 > T_RODADA) ? M2 : T_RODADA;
    localparam int TW     = $clog2(T_MAX + 1);
    localparam int AW     = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1;

    localparam logic [TW-1:0] FIM_JOGAR     = TW'(T_JOGAR - 1);
    localparam logic [TW-1:0] FIM_INICIO    = TW'(T_INICIO - 1);
    localparam logic [TW-1:0] FIM_APERTO    = TW'(T_APERTO - 1);
    localparam logic [TW-1:0] FIM_INTERVALO = TW'(T_INTERVALO - 1);
    localparam logic [TW-1:0] FIM_NOVA      = TW'(T_NOVA - 1);
    localparam logic [TW-1:0] FIM_RODADA    = TW'(T_RODADA - 1);
    localparam logic [TW-1:0] LIM_APERTO    = TW'(T_APERTO);
    localparam logic [TW-1:0] TIMER_MAX     = TW'(T_MAX);
    localparam logic [3:0]    ULTIMA        = 4'(N_JOGADAS - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PULSA_JOGAR   = 4'h1,
        ESPERA_INICIO = 4'h2,
        APERTA        = 4'h3,
        SOLTA         = 4'h4,
        PROXIMO       = 4'h5,
        NOVA_JOGADA   = 4'h6,
        APERTA_NOVA   = 4'h7,
        ESPERA_RODADA = 4'h8,
        ESPERA_FIM    = 4'h9,
        FIM           = 4'hF
    } estado_t;

    estado_t       estado, estado_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    rodada, rodada_nxt;
    logic [3:0]    endereco, endereco_nxt;
    logic [3:0]    rodada_p1;
    logic [3:0]    lfsr;
    logic [3:0]    jogada;
    logic [3:0]    botoes_nxt;
    logic          grava;
    logic [AW-1:0] grava_end;
    logic [3:0]    mem [N_JOGADAS];

    always_comb begin
        jogada = 4'b0001;
        case (lfsr[1:0])
            2'b00:   jogada = 4'b0001;
            2'b01:   jogada = 4'b0010;
            2'b10:   jogada = 4'b0100;
            default: jogada = 4'b1000;
        endcase
    end

    assign rodada_p1 = rodada + 4'd1;

    always_comb begin
        estado_nxt   = estado;
        rodada_nxt   = rodada;
        endereco_nxt = endereco;
        grava        = 1'b0;
        grava_end    = '0;
        botoes_nxt   = 4'b0000;
        case (estado)
            INICIAL:       if (habilitar) estado_nxt = PULSA_JOGAR;
            PULSA_JOGAR:   if (timer == FIM_JOGAR) estado_nxt = ESPERA_INICIO;
            ESPERA_INICIO: if (timer == FIM_INICIO) estado_nxt = APERTA;
            APERTA:        if (timer == FIM_APERTO) estado_nxt = SOLTA;
            SOLTA:         if (timer == FIM_INTERVALO) estado_nxt = PROXIMO;
            PROXIMO: begin
                if (endereco < rodada) begin
                    endereco_nxt = endereco + 4'd1;
                    estado_nxt   = APERTA;
                end else if (rodada == ULTIMA) begin
                    estado_nxt = ESPERA_FIM;
                end else begin
                    estado_nxt = NOVA_JOGADA;
                end
            end
            NOVA_JOGADA: begin
                grava      = 1'b1;
                grava_end  = rodada_p1[AW-1:0];
                estado_nxt = APERTA_NOVA;
            end
            APERTA_NOVA:   if (timer == FIM_NOVA) estado_nxt = ESPERA_RODADA;
            ESPERA_RODADA: begin
                if (timer == FIM_RODADA) begin
                    rodada_nxt   = rodada_p1;
                    endereco_nxt = 4'd0;
                    estado_nxt   = APERTA;
                end
            end
            ESPERA_FIM:    estado_nxt = ESPERA_FIM;
            FIM:           estado_nxt = FIM;
            default:       estado_nxt = INICIAL;
        endcase

        // Abort paths outrank every timer; losing the enable outranks game status.
        if (estado != INICIAL && estado != FIM && (pronto || ganhou || perdeu))
            estado_nxt = FIM;
        if (estado != INICIAL && !habilitar)
            estado_nxt = INICIAL;

        if (estado_nxt == PULSA_JOGAR && estado != PULSA_JOGAR) begin
            rodada_nxt   = 4'd0;
            endereco_nxt = 4'd0;
            grava        = 1'b1;
            grava_end    = '0;
        end

        if (estado_nxt != estado)
            timer_nxt = '0;
        else if (timer == TIMER_MAX)
            timer_nxt = timer;
        else
            timer_nxt = timer + 1'b1;

        // Outputs are decoded from the next state so the registers line up with the state.
        // The new move is bypassed because its memory write lands on the same edge.
        if (estado_nxt == APERTA)
            botoes_nxt = mem[endereco_nxt[AW-1:0]];
        else if (estado_nxt == APERTA_NOVA && timer_nxt < LIM_APERTO)
            botoes_nxt = (estado == NOVA_JOGADA) ? jogada : mem[rodada_p1[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado   <= INICIAL;
            timer    <= '0;
            rodada   <= 4'd0;
            endereco <= 4'd0;
            lfsr     <= 4'b1001;
            jogar    <= 1'b0;
            fim      <= 1'b0;
            botoes   <= 4'b0000;
        end else begin
            estado   <= estado_nxt;
            timer    <= timer_nxt;
            rodada   <= rodada_nxt;
            endereco <= endereco_nxt;
            lfsr     <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            jogar    <= (estado_nxt == PULSA_JOGAR);
            fim      <= (estado_nxt == FIM);
            botoes   <= botoes_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && grava)
            mem[grava_end] <= jogada;
    end

    assign db_estado = estado;
    assign db_rodada = rodada;

endmodule

// File: tb/tb_jogador_automatico.sv
// tb/tb_jogador_automatico.sv - randomized self-checking bench for jogador_automatico
module tb_jogador_automatico;

    localparam int BOUND = 1000;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hab = 1'b0, pronto = 1'b0, ganhou = 1'b0, perdeu = 1'b0;
    logic       jogar, fim;
    logic [3:0] botoes, db_rodada, db_estado;
    logic       hab4 = 1'b0, pronto4 = 1'b0, ganhou4 = 1'b0, perdeu4 = 1'b0;
    logic       jogar4, fim4;
    logic [3:0] botoes4, rodada4, estado4;

    int errors = 0;
    int checks = 0;
    int viol = 0;
    logic [3:0] m_lfsr;
    logic [3:0] last_lfsr;
    logic [3:0] m0, m1, m2;

    jogador_automatico #(.T_INICIO(50)) dut (
        .clock(clock), .reset(reset), .habilitar(hab), .pronto(pronto),
        .ganhou(ganhou), .perdeu(perdeu), .jogar(jogar), .botoes(botoes),
        .fim(fim), .db_rodada(db_rodada), .db_estado(db_estado)
    );

    jogador_automatico #(.T_INICIO(50), .N_JOGADAS(4)) dut4 (
        .clock(clock), .reset(reset), .habilitar(hab4), .pronto(pronto4),
        .ganhou(ganhou4), .perdeu(perdeu4), .jogar(jogar4), .botoes(botoes4),
        .fim(fim4), .db_rodada(rodada4), .db_estado(estado4)
    );

    always #5 clock = ~clock;

    // Move source: 4-bit LFSR, taps 4 and 3, seed 1001, one step per clock.
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 4'b1001;
        else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if ($countones(botoes) > 1)  viol++;
            if ($countones(botoes4) > 1) viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    task automatic tick;
        last_lfsr = m_lfsr;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b0; hab = 1'b0;
        repeat (3) tick();
        checks++; if (botoes !== 4'b0) begin errors++; $display("FAIL reset_botoes: got %b want 0000", botoes); end
        checks++; if (jogar !== 1'b0) begin errors++; $display("FAIL reset_jogar: got %b want 0", jogar); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL reset_fim: got %b want 0", fim); end
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_estado: got %h want 0", db_estado); end
        checks++; if (db_rodada !== 4'h0) begin errors++; $display("FAIL reset_rodada: got %h want 0", db_rodada); end
        checks++; if (estado4 !== 4'h0) begin errors++; $display("FAIL reset_estado4: got %h want 0", estado4); end
        reset = 1'b1;
        repeat ($urandom_range(1, 7)) tick();
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL idle_no_enable: got %h want 0", db_estado); end
    endtask

    task automatic test_start;
        int n;
        hab = 1'b1;
        tick();
        m0 = onehot(last_lfsr[1:0]);
        n = 0; while (jogar === 1'b1 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 10) begin errors++; $display("FAIL jogar_width: got %0d want 10", n); end
        n = 0; while (jogar === 1'b0 && botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 50) begin errors++; $display("FAIL inicio_wait: got %0d want 50", n); end
        checks++; if (botoes !== m0) begin errors++; $display("FAIL first_press: got %b want %b", botoes, m0); end
        n = 0; while (botoes === m0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 10) begin errors++; $display("FAIL first_hold: got %0d want 10", n); end
    endtask

    task automatic test_round0;
        int n;
        n = 0; while (botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 12) begin errors++; $display("FAIL gap_before_new: got %0d want 12", n); end
        m1 = onehot(last_lfsr[1:0]);
        checks++; if (botoes !== m1) begin errors++; $display("FAIL new_move1: got %b want %b", botoes, m1); end
        n = 0; while (botoes === m1 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 10) begin errors++; $display("FAIL new_hold1: got %0d want 10", n); end
        n = 0; while (botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 110) begin errors++; $display("FAIL rodada_wait: got %0d want 110", n); end
        checks++; if (db_rodada !== 4'd1) begin errors++; $display("FAIL rodada_1: got %0d want 1", db_rodada); end
        checks++; if (botoes !== m0) begin errors++; $display("FAIL replay0: got %b want %b", botoes, m0); end
        n = 0; while (botoes === m0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 10) begin errors++; $display("FAIL replay0_hold: got %0d want 10", n); end
        n = 0; while (botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 11) begin errors++; $display("FAIL replay_gap: got %0d want 11", n); end
        checks++; if (botoes !== m1) begin errors++; $display("FAIL replay1: got %b want %b", botoes, m1); end
        n = 0; while (botoes === m1 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 10) begin errors++; $display("FAIL replay1_hold: got %0d want 10", n); end
        n = 0; while (botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 12) begin errors++; $display("FAIL gap_before_new2: got %0d want 12", n); end
        m2 = onehot(last_lfsr[1:0]);
        checks++; if (botoes !== m2) begin errors++; $display("FAIL new_move2: got %b want %b", botoes, m2); end
        n = 0; while (botoes === m2 && n < BOUND) begin n++; tick(); end
        n = 0; while (botoes === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 110) begin errors++; $display("FAIL rodada_wait2: got %0d want 110", n); end
    endtask

    task automatic test_perdeu;
        logic held_ok;
        repeat ($urandom_range(0, 8)) tick();
        checks++; if (botoes !== m0) begin errors++; $display("FAIL mid_hold: got %b want %b", botoes, m0); end
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        checks++; if (botoes !== 4'b0) begin errors++; $display("FAIL perdeu_botoes: got %b want 0000", botoes); end
        checks++; if (fim !== 1'b1) begin errors++; $display("FAIL perdeu_fim: got %b want 1", fim); end
        checks++; if (db_estado !== 4'hF) begin errors++; $display("FAIL perdeu_estado: got %h want F", db_estado); end
        held_ok = 1'b1;
        repeat ($urandom_range(3, 20)) begin
            tick();
            if (fim !== 1'b1 || botoes !== 4'b0) held_ok = 1'b0;
        end
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL fim_held: got %b want 1", held_ok); end
        hab = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL fim_exit: got %h want 0", db_estado); end
        checks++; if (fim !== 1'b0) begin errors++; $display("FAIL fim_clear: got %b want 0", fim); end
    endtask

    task automatic test_abort;
        int td;
        repeat ($urandom_range(1, 15)) tick();
        hab = 1'b1;
        tick();
        checks++; if (jogar !== 1'b1) begin errors++; $display("FAIL restart_jogar: got %b want 1", jogar); end
        td = 265 + $urandom_range(0, 99);
        repeat (td) tick();
        checks++; if (db_estado !== 4'h8) begin errors++; $display("FAIL in_espera_rodada: got %h want 8 (t=%0d)", db_estado, td); end
        checks++; if (db_rodada !== 4'd1) begin errors++; $display("FAIL abort_rodada: got %0d want 1", db_rodada); end
        hab = 1'b0;
        tick();
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL abort_estado: got %h want 0", db_estado); end
        checks++; if (botoes !== 4'b0) begin errors++; $display("FAIL abort_botoes: got %b want 0000", botoes); end
        repeat ($urandom_range(1, 5)) tick();
        hab = 1'b1;
        tick();
        checks++; if (db_estado !== 4'h1) begin errors++; $display("FAIL rearm_estado: got %h want 1", db_estado); end
        checks++; if (db_rodada !== 4'd0) begin errors++; $display("FAIL rearm_rodada: got %0d want 0", db_rodada); end
        hab = 1'b0;
        tick();
    endtask

    task automatic test_full_game;
        logic [3:0] mv [4];
        int n, lim;
        repeat ($urandom_range(1, 20)) tick();
        hab4 = 1'b1;
        tick();
        mv[0] = onehot(last_lfsr[1:0]);
        n = 0; while (jogar4 === 1'b1 && n < BOUND) begin n++; tick(); end
        n = 0; while (jogar4 === 1'b0 && botoes4 === 4'b0 && n < BOUND) begin n++; tick(); end
        checks++; if (n !== 50) begin errors++; $display("FAIL n4_inicio: got %0d want 50", n); end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k <= r; k++) begin
                checks++; if (botoes4 !== mv[k]) begin errors++; $display("FAIL n4_replay r%0d k%0d: got %b want %b", r, k, botoes4, mv[k]); end
                n = 0; while (botoes4 === mv[k] && n < BOUND) begin n++; tick(); end
                checks++; if (n !== 10) begin errors++; $display("FAIL n4_hold r%0d k%0d: got %0d want 10", r, k, n); end
                lim = (r == 3 && k == 3) ? 200 : BOUND;
                n = 0; while (botoes4 === 4'b0 && n < lim) begin n++; tick(); end
                if (k < r) begin
                    checks++; if (n !== 11) begin errors++; $display("FAIL n4_gap r%0d k%0d: got %0d want 11", r, k, n); end
                end else if (r < 3) begin
                    checks++; if (n !== 12) begin errors++; $display("FAIL n4_pre_new r%0d: got %0d want 12", r, n); end
                    mv[r+1] = onehot(last_lfsr[1:0]);
                    checks++; if (botoes4 !== mv[r+1]) begin errors++; $display("FAIL n4_new r%0d: got %b want %b", r, botoes4, mv[r+1]); end
                    n = 0; while (botoes4 === mv[r+1] && n < BOUND) begin n++; tick(); end
                    n = 0; while (botoes4 === 4'b0 && n < BOUND) begin n++; tick(); end
                    checks++; if (n !== 110) begin errors++; $display("FAIL n4_wait r%0d: got %0d want 110", r, n); end
                    checks++; if (rodada4 !== 4'(r + 1)) begin errors++; $display("FAIL n4_rodada: got %0d want %0d", rodada4, r + 1); end
                end else begin
                    checks++; if (n !== 200) begin errors++; $display("FAIL n4_no_new_move: got %0d idle cycles want 200", n); end
                    checks++; if (estado4 !== 4'h9) begin errors++; $display("FAIL n4_espera_fim: got %h want 9", estado4); end
                end
            end
        end
        ganhou4 = 1'b1;
        tick();
        ganhou4 = 1'b0;
        checks++; if (estado4 !== 4'hF) begin errors++; $display("FAIL n4_ganhou_estado: got %h want F", estado4); end
        checks++; if (fim4 !== 1'b1) begin errors++; $display("FAIL n4_ganhou_fim: got %b want 1", fim4); end
        hab4 = 1'b0;
        tick();
        checks++; if (estado4 !== 4'h0) begin errors++; $display("FAIL n4_exit: got %h want 0", estado4); end
    endtask

    task automatic test_reset_midpress;
        logic [3:0] ms;
        hab = 1'b1;
        tick();
        ms = onehot(last_lfsr[1:0]);
        repeat (60 + $urandom_range(0, 8)) tick();
        checks++; if (botoes !== ms) begin errors++; $display("FAIL pre_reset_press: got %b want %b", botoes, ms); end
        reset = 1'b0;
        tick();
        checks++; if (botoes !== 4'b0) begin errors++; $display("FAIL reset_midpress_botoes: got %b want 0000", botoes); end
        checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_midpress_estado: got %h want 0", db_estado); end
        reset = 1'b1;
        hab = 1'b0;
        tick();
    endtask

    task automatic test_onehot;
        checks++; if (viol !== 0) begin errors++; $display("FAIL onehot: got %0d multi-bit samples want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round0();
        test_perdeu();
        test_abort();
        test_full_game();
        test_reset_midpress();
        test_onehot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
